// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that runs one 1-bit full adder over N cycles, LSB first.
// Latency: start sampled at edge k -> done high in the cycle after edge k+N; one op per N+1 cycles.
// Backpressure: none; start is only honoured in IDLE or DONE and is ignored while busy.
//
// Optional feature macro: SERIAL_SUB_EN (adds the sub port and subtract-by-complement logic).
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset, overrides start
//   start  - request to begin an operation (accepted in IDLE or DONE)
//   a, b   - N-bit operands, sampled only at the accepting edge
//   cin    - carry-in for bit 0, sampled only at the accepting edge
//   sub    - subtract request (only with SERIAL_SUB_EN): sum = a - b, cout = no-borrow
//   busy   - high while bits are being processed
//   done   - one-cycle completion pulse
//   sum    - result, held until the next result load
//   cout   - final carry, held with sum
module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  res_sh;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sum_q;
  logic          cout_q;

  logic          accept;
  logic          last_bit;
  logic          bit_s;
  logic          bit_c;
  logic [N-1:0]  b_load;
  logic          c_load;

  // Single full adder on the current LSBs.
  assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // Subtraction is a + ~b + 1, so only the loaded b and carry differ.
`ifdef SERIAL_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(N - 1)) begin
          last_bit   = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start here re-arms directly, giving the N+1 cycle repeat rate.
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, carry, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b_load;
      carry  <= c_load;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      // Sum bits enter from the MSB side so bit 0 ends up at position 0 after N shifts.
      res_sh <= {bit_s, res_sh[N-1:1]};
      carry  <= bit_c;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum_q  <= {bit_s, res_sh[N-1:1]};
        cout_q <= bit_c;
      end
    end
  end

  // Outputs only move on the final-bit edge, so they are stable through RUN.
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub_i;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int total;
  int bad;

  serial_add_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the spec's rules.
  function automatic logic [8:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                        input logic rc, input logic rs);
    int r;
    if (rs) r = int'(ra) + int'(8'hFF - rb) + 1;
    else    r = int'(ra) + int'(rb) + int'(rc);
    return r[8:0];
  endfunction

  // Launch one operation, scramble inputs during RUN, return result, latency and busy health.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic ts, output logic [7:0] rs, output logic rc,
                       output int lat, output int busy_err);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub_i = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_err = 0;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_err++;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub_i = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) busy_err++;
    rs = sum;
    rc = cout;
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc;
    logic [8:0] exp;
    logic [7:0] hs;
    logic       hc;
    logic       use_sub;
    logic [7:0] x1, y1, x2, y2;
    int         lat;
    int         berr;
    int         gap;
    int         seen_done;

    total = 0;
    bad   = 0;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h5A, 8'h25, 1'b1, 8'h80, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors, each with latency and busy-window checks.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vc, 1'b0, rs, rc, lat, berr);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].es));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].ec));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(N + 1));
      chk($sformatf("vec%0d_busy", i), 32'(berr), 32'd0);
    end

    // Hold: last vector left sum=FF cout=0; change operands in IDLE.
    hs = sum; hc = cout;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      chk("hold_done_low", 32'(done), 32'd0);
    end
    chk("hold_sum", 32'(sum), 32'hFF);
    chk("hold_cout", 32'(cout), 32'd0);
    chk("hold_sum_stable", 32'(sum), 32'(hs));
    chk("hold_cout_stable", 32'(cout), 32'(hc));

    // Back-to-back with start held high; second operands present at DONE edge.
    x1 = 8'h3C; y1 = 8'hD9; x2 = 8'h71; y2 = 8'h0E;
    @(negedge clk);
    a = x1; b = y1; cin = 1'b0; sub_i = 1'b0; start = 1'b1;
    @(negedge clk);
    a = x2; b = y2;
    lat = 1;
    while (!done && lat < 40) begin
      chk("b2b_sum_still_in_run", 32'(sum), 32'hFF);
      @(negedge clk); lat++;
    end
    exp = ref_op(x1, y1, 1'b0, 1'b0);
    chk("b2b_first_latency", 32'(lat), 32'(N + 1));
    chk("b2b_first_sum", 32'(sum), 32'(exp[7:0]));
    chk("b2b_first_cout", 32'(cout), 32'(exp[8]));
    @(negedge clk);
    gap = 1;
    chk("b2b_rearm_busy", 32'(busy), 32'd1);
    while (!done && gap < 40) begin
      @(negedge clk); gap++;
    end
    start = 1'b0;
    exp = ref_op(x2, y2, 1'b0, 1'b0);
    chk("b2b_gap", 32'(gap), 32'(N + 1));
    chk("b2b_second_sum", 32'(sum), 32'(exp[7:0]));
    chk("b2b_second_cout", 32'(cout), 32'(exp[8]));
    @(negedge clk);

    // Reset at the 4th RUN cycle.
    @(negedge clk);
    a = 8'h9F; b = 8'h44; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_reset_was_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_done", 32'(done), 32'd0);
    chk("mid_reset_sum",  32'(sum),  32'd0);
    chk("mid_reset_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("mid_reset_no_done", 32'(seen_done), 32'd0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, lat, berr);
    chk("post_reset_sum", 32'(rs), 32'h00);
    chk("post_reset_cout", 32'(rc), 32'd1);
    chk("post_reset_latency", 32'(lat), 32'(N + 1));

`ifdef SERIAL_SUB_EN
    do_op(8'h05, 8'h07, 1'b0, 1'b1, rs, rc, lat, berr);
    chk("sub_5_7_sum", 32'(rs), 32'hFE);
    chk("sub_5_7_cout", 32'(rc), 32'd0);
    do_op(8'h07, 8'h05, 1'b1, 1'b1, rs, rc, lat, berr);
    chk("sub_7_5_sum", 32'(rs), 32'h02);
    chk("sub_7_5_cout", 32'(rc), 32'd1);
`endif

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      x1 = 8'($urandom);
      y1 = 8'($urandom);
      hc = 1'($urandom);
`ifdef SERIAL_SUB_EN
      use_sub = 1'($urandom);
`else
      use_sub = 1'b0;
`endif
      exp = ref_op(x1, y1, hc, use_sub);
      do_op(x1, y1, hc, use_sub, rs, rc, lat, berr);
      chk($sformatf("rand%0d_result", i), {23'd0, rc, rs}, 32'(exp));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(N + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
